instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Issuer side of the EXEC instruction interface: owns the PC, fetches 16-bit words from instruction memory
//  over a req/ack handshake and presents each as EXEC/EXEC_VALID to the decode/control stage.
//  Accepts branch redirects from execute and stops on HLT. Sits between instruction memory and the control unit.
// PARAMETERS
//  ADDR_W    16     instruction address width (word-addressed)
//  RESET_PC  16'h0  PC value loaded on reset
// PORTS
//  CLOCK       in   1       single clock, all state updates on posedge
//  RESET       in   1       synchronous, active-low reset
//  IMEM_REQ    out  1       fetch request; held high until IMEM_ACK
//  IMEM_ADDR   out  ADDR_W  fetch address; stable while IMEM_REQ high
//  IMEM_ACK    in   1       one-cycle pulse, IMEM_RDATA valid same cycle
//  IMEM_RDATA  in   16      fetched instruction word
//  EXEC        out  16      instruction to control unit
//  EXEC_VALID  out  1       EXEC holds a live instruction
//  EXEC_READY  in   1       consumer takes EXEC this cycle when EXEC_VALID&EXEC_READY
//  BR_TAKEN    in   1       execute-stage redirect pulse
//  BR_TARGET   in   ADDR_W  redirect address, valid with BR_TAKEN
//  HALTED      out  1       HLT retired; fetch stopped
// BEHAVIOUR
//  - Reset (RESET==0 at posedge): PC=RESET_PC, state=FETCH, IMEM_REQ=0, IMEM_ADDR=RESET_PC, EXEC=16'h0,
//    EXEC_VALID=0, HALTED=0, squash=0. Reset mid-transaction abandons it; a late IMEM_ACK after reset is ignored.
//  - FSM: FETCH -> (IMEM_REQ=1, IMEM_ADDR=PC) WAIT -> on IMEM_ACK: EXEC<=IMEM_RDATA, EXEC_VALID<=1, PC<=PC+1, -> HOLD
//    HOLD -> on EXEC_VALID&EXEC_READY: EXEC_VALID<=0; HLT word -> HALTED else -> FETCH. HALTED is absorbing until reset.
//  - Latency: IMEM_REQ rises the cycle after entering FETCH; EXEC_VALID rises the cycle after IMEM_ACK.
//    Min 3 cycles/instruction (FETCH, WAIT with same-cycle ack, HOLD with READY=1).
//  - HLT decode: EXEC[15:14]==2'b11 && EXEC[7:4]==4'b1111. Only on acceptance; HALTED=1 next cycle, IMEM_REQ stays 0.
//  - PC arithmetic modulo 2^ADDR_W; PC=all-ones +1 wraps to 0, no flag.
//  - BR_TAKEN (any state except HALTED): PC<=BR_TARGET, EXEC_VALID<=0, next state FETCH.
//    In WAIT: IMEM_REQ drops next cycle; if IMEM_ACK in same cycle as BR_TAKEN, data discarded.
//    If IMEM_REQ was high and no ack yet, set squash; next IMEM_ACK is dropped (clears squash), and FETCH
//    does not assert IMEM_REQ while squash=1.
//  - BR_TAKEN simultaneous with EXEC_VALID&EXEC_READY: handshake completes (consumer has word), redirect wins PC.
//  - BR_TAKEN while HALTED: ignored.
// CONFIGURATION
//  FETCH_PREDECODE_EN defined: on IMEM_ACK of unconditional B (RDATA[15:14]==2'b10 && RDATA[13:11]==3'b100),
//    PC<=PC+1+sext(RDATA[7:0]) instead of PC+1; word still presented on EXEC. Execute must not redirect on B.
//  Undefined: PC<=PC+1 always; all branches resolved via BR_TAKEN.
// STRUCTURE
//  Shared package simple_isa_pkg: class codes (CLS_LD/ST/BR/ALU), BR subop codes (LI, B, BCOND),
//    cond codes (BE/BLT/BLE/BNE), ALU func HLT=4'b1111, fetch state enum, is_hlt()/is_uncond_b() functions.
//  Single module, no sub-modules; predecode is a package function, not an instance.
// TESTING
//  1 Reset, mem returns 0x4000,0x8001,0xC0F0(HLT), READY=1, ACK 1 cycle after REQ -> EXEC seq as given,
//    IMEM_ADDR 0,1,2, HALTED=1 after third accept, IMEM_REQ stays 0 for 20 cycles.
//  2 EXEC_READY held 0 for 5 cycles after VALID -> EXEC/VALID stable, no new IMEM_REQ, PC unchanged.
//  3 BR_TAKEN target 0x0040 while in WAIT, ACK 2 cycles later with 0x1234 -> 0x1234 never on EXEC,
//    next IMEM_ADDR=0x0040.
//  4 BR_TAKEN in same cycle as IMEM_ACK -> word dropped, EXEC_VALID stays 0, fetch from BR_TARGET.
//  5 RESET_PC=16'hFFFF -> addresses FFFF then 0000 (wrap).
//  6 FETCH_PREDECODE_EN: word 0xA0FE (B, d=-2) at PC 0x10 -> next IMEM_ADDR=0x000F; undefined -> 0x0011.

Source files
------------

// File: rtl/simple_isa_pkg.sv
// ----------------------------------------------------------------------------
// simple_isa_pkg
//   Shared ISA definitions for the simple 16-bit machine: instruction class
//   codes, branch sub-op and condition codes, the HLT ALU function code, the
//   fetch-unit state encoding and small decode helpers used by fetch.
//   Encoding: [15:14] class, [13:11] branch sub-op, [7:4] ALU func,
//             [7:0] signed branch displacement.
// ----------------------------------------------------------------------------
package simple_isa_pkg;

   typedef enum logic [1:0] {
      CLS_LD  = 2'b00,
      CLS_ST  = 2'b01,
      CLS_BR  = 2'b10,
      CLS_ALU = 2'b11
   } isa_class_t;

   typedef enum logic [2:0] {
      BR_LI    = 3'b000,
      BR_BCOND = 3'b010,
      BR_B     = 3'b100
   } br_subop_t;

   typedef enum logic [1:0] {
      COND_BE  = 2'b00,
      COND_BLT = 2'b01,
      COND_BLE = 2'b10,
      COND_BNE = 2'b11
   } br_cond_t;

   localparam logic [3:0] ALU_HLT = 4'b1111;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_WAIT,
      ST_HOLD,
      ST_HALT
   } fetch_state_t;

   // cls = word[15:14], func = word[7:4]
   function automatic logic is_hlt(input logic [1:0] cls, input logic [3:0] func);
      return (cls == CLS_ALU) && (func == ALU_HLT);
   endfunction

   // op = word[15:11] (class + branch sub-op)
   function automatic logic is_uncond_b(input logic [4:0] op);
      return (op[4:3] == CLS_BR) && (op[2:0] == BR_B);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit_if
//   Bundles the fetch unit's instruction-memory handshake, the EXEC
//   presentation handshake, the execute-stage redirect and the halt status.
//   master : fetch unit (drives IMEM_REQ/IMEM_ADDR, EXEC/EXEC_VALID, HALTED)
//   slave  : memory + decode/execute side (drives IMEM_ACK/IMEM_RDATA,
//            EXEC_READY, BR_TAKEN/BR_TARGET)
// ----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              IMEM_REQ;
   logic [ADDR_W-1:0] IMEM_ADDR;
   logic              IMEM_ACK;
   logic [15:0]       IMEM_RDATA;
   logic [15:0]       EXEC;
   logic              EXEC_VALID;
   logic              EXEC_READY;
   logic              BR_TAKEN;
   logic [ADDR_W-1:0] BR_TARGET;
   logic              HALTED;

   modport master (
      output IMEM_REQ, IMEM_ADDR, EXEC, EXEC_VALID, HALTED,
      input  IMEM_ACK, IMEM_RDATA, EXEC_READY, BR_TAKEN, BR_TARGET
   );

   modport slave (
      input  IMEM_REQ, IMEM_ADDR, EXEC, EXEC_VALID, HALTED,
      output IMEM_ACK, IMEM_RDATA, EXEC_READY, BR_TAKEN, BR_TARGET
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
//   Owns the PC, fetches 16-bit words over a req/ack handshake and presents
//   each on EXEC/EXEC_VALID until the control unit accepts it. Execute-stage
//   redirects reload the PC; a retired HLT stops fetch until reset.
// Ports
//   CLOCK : single clock, posedge
//   RESET : synchronous, active-low
//   bus   : instruction_fetch_unit_if.master (IMEM_*, EXEC*, BR_*, HALTED)
// Parameters
//   ADDR_W   : instruction address width (word addressed)
//   RESET_PC : PC loaded on reset
// Configuration
//   FETCH_PREDECODE_EN : when defined, an unconditional B returned by memory
//                        redirects the PC at fetch time (PC+1+sext(disp)).
// ----------------------------------------------------------------------------
module instruction_fetch_unit
   import simple_isa_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                      CLOCK,
   input logic                      RESET,
   instruction_fetch_unit_if.master bus
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_after_ack;
   logic              squash;
   logic              accept;

   assign accept = bus.EXEC_VALID & bus.EXEC_READY;

`ifdef FETCH_PREDECODE_EN
   always_comb begin
      pc_after_ack = pc + 1'b1;
      if (is_uncond_b(bus.IMEM_RDATA[15:11]))
         pc_after_ack = pc + 1'b1 +
                        {{(ADDR_W-8){bus.IMEM_RDATA[7]}}, bus.IMEM_RDATA[7:0]};
   end
`else
   assign pc_after_ack = pc + 1'b1;
`endif

   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         state          <= ST_FETCH;
         pc             <= RESET_PC;
         squash         <= 1'b0;
         bus.IMEM_REQ   <= 1'b0;
         bus.IMEM_ADDR  <= RESET_PC;
         bus.EXEC       <= '0;
         bus.EXEC_VALID <= 1'b0;
         bus.HALTED     <= 1'b0;
      end else begin
         // The ack owed to an abandoned request is swallowed wherever it lands.
         if (squash && bus.IMEM_ACK)
            squash <= 1'b0;

         unique case (state)
            ST_FETCH: begin
               if (bus.BR_TAKEN) begin
                  pc <= bus.BR_TARGET;
               end else if (!squash) begin
                  bus.IMEM_REQ  <= 1'b1;
                  bus.IMEM_ADDR <= pc;
                  state         <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (bus.BR_TAKEN) begin
                  // Request still outstanding unless acked this very cycle.
                  bus.IMEM_REQ <= 1'b0;
                  pc           <= bus.BR_TARGET;
                  squash       <= ~bus.IMEM_ACK;
                  state        <= ST_FETCH;
               end else if (bus.IMEM_ACK) begin
                  bus.IMEM_REQ   <= 1'b0;
                  bus.EXEC       <= bus.IMEM_RDATA;
                  bus.EXEC_VALID <= 1'b1;
                  pc             <= pc_after_ack;
                  state          <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (bus.BR_TAKEN) begin
                  // Redirect wins the PC even if the word was accepted now.
                  bus.EXEC_VALID <= 1'b0;
                  pc             <= bus.BR_TARGET;
                  state          <= ST_FETCH;
               end else if (accept) begin
                  bus.EXEC_VALID <= 1'b0;
                  if (is_hlt(bus.EXEC[15:14], bus.EXEC[7:4])) begin
                     bus.HALTED <= 1'b1;
                     state      <= ST_HALT;
                  end else begin
                     state <= ST_FETCH;
                  end
               end
            end

            ST_HALT: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.ADDR_W(16)) b1 ();
   instruction_fetch_unit_if #(.ADDR_W(16)) b2 ();

   instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .CLOCK(clk),
      .RESET(rst_n),
      .bus  (b1.master)
   );

   instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
      .CLOCK(clk),
      .RESET(rst_n),
      .bus  (b2.master)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; waits (bounded) for b1 to raise IMEM_REQ.
   task automatic wait_req(input string tag);
      int unsigned n = 0;
      while (b1.IMEM_REQ !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_req"}, {31'd0, b1.IMEM_REQ}, 32'd1);
   endtask

   // Wait for a request, check its address, ack after lat cycles with data.
   // Returns at the negedge after the ack edge.
   task automatic serve(input string tag, input logic [15:0] addr_exp,
                        input logic [15:0] data, input int unsigned lat);
      wait_req(tag);
      check({tag, "_addr"}, {16'd0, b1.IMEM_ADDR}, {16'd0, addr_exp});
      repeat (lat) @(negedge clk);
      check({tag, "_addr_hold"}, {16'd0, b1.IMEM_ADDR}, {16'd0, addr_exp});
      b1.IMEM_ACK   = 1'b1;
      b1.IMEM_RDATA = data;
      @(negedge clk);
      b1.IMEM_ACK   = 1'b0;
      b1.IMEM_RDATA = 16'h0000;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req",    {31'd0, b1.IMEM_REQ},   32'd0);
      check("rst_addr",   {16'd0, b1.IMEM_ADDR},  32'h0000);
      check("rst_exec",   {16'd0, b1.EXEC},       32'h0000);
      check("rst_valid",  {31'd0, b1.EXEC_VALID}, 32'd0);
      check("rst_halted", {31'd0, b1.HALTED},     32'd0);
      check("rst_addr_w", {16'd0, b2.IMEM_ADDR},  32'hFFFF);
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned cnt;
      int unsigned n;

      rst_n         = 1'b0;
      b1.IMEM_ACK   = 1'b0;
      b1.IMEM_RDATA = 16'h0000;
      b1.EXEC_READY = 1'b1;
      b1.BR_TAKEN   = 1'b0;
      b1.BR_TARGET  = 16'h0000;
      b2.IMEM_ACK   = 1'b0;
      b2.IMEM_RDATA = 16'h0000;
      b2.EXEC_READY = 1'b1;
      b2.BR_TAKEN   = 1'b0;
      b2.BR_TARGET  = 16'h0000;
      @(negedge clk);
      do_reset();

      // 1: three-word program ending in HLT
      serve("t1w0", 16'h0000, 16'h4000, 1);
      check("t1w0_exec",  {16'd0, b1.EXEC},       32'h4000);
      check("t1w0_valid", {31'd0, b1.EXEC_VALID}, 32'd1);
      serve("t1w1", 16'h0001, 16'h8001, 1);
      check("t1w1_exec",  {16'd0, b1.EXEC},       32'h8001);
      serve("t1w2", 16'h0002, 16'hC0F0, 1);
      check("t1w2_exec",  {16'd0, b1.EXEC},       32'hC0F0);
      check("t1w2_nohalt_yet", {31'd0, b1.HALTED}, 32'd0);
      @(negedge clk);
      check("t1_halted",  {31'd0, b1.HALTED},     32'd1);
      check("t1_valid0",  {31'd0, b1.EXEC_VALID}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            b1.BR_TAKEN  = 1'b1;
            b1.BR_TARGET = 16'h0033;
         end else begin
            b1.BR_TAKEN = 1'b0;
         end
         @(negedge clk);
         if (b1.IMEM_REQ !== 1'b0) cnt++;
      end
      check("t1_req_idle_cycles", cnt, 32'd0);
      check("t1_still_halted", {31'd0, b1.HALTED}, 32'd1);

      // 2: consumer stalls for 5 cycles
      b1.EXEC_READY = 1'b0;
      do_reset();
      serve("t2", 16'h0000, 16'h1111, 1);
      check("t2_valid", {31'd0, b1.EXEC_VALID}, 32'd1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (b1.EXEC_VALID !== 1'b1 || b1.EXEC !== 16'h1111 || b1.IMEM_REQ !== 1'b0) cnt++;
      end
      check("t2_stall_stable", cnt, 32'd0);
      b1.EXEC_READY = 1'b1;
      serve("t2n", 16'h0001, 16'h2222, 0);
      check("t2n_exec", {16'd0, b1.EXEC}, 32'h2222);

      // 3: redirect while waiting; late ack must be dropped
      wait_req("t3");
      check("t3_addr", {16'd0, b1.IMEM_ADDR}, 32'h0002);
      b1.BR_TAKEN  = 1'b1;
      b1.BR_TARGET = 16'h0040;
      @(negedge clk);
      b1.BR_TAKEN = 1'b0;
      check("t3_req_drop", {31'd0, b1.IMEM_REQ}, 32'd0);
      @(negedge clk);
      check("t3_req_squash", {31'd0, b1.IMEM_REQ}, 32'd0);
      b1.IMEM_ACK   = 1'b1;
      b1.IMEM_RDATA = 16'h1234;
      @(negedge clk);
      b1.IMEM_ACK   = 1'b0;
      b1.IMEM_RDATA = 16'h0000;
      check("t3_valid_after_late_ack", {31'd0, b1.EXEC_VALID}, 32'd0);
      check("t3_exec_not_1234", {31'd0, (b1.EXEC === 16'h1234)}, 32'd0);
      serve("t3n", 16'h0040, 16'h5555, 1);
      check("t3n_exec", {16'd0, b1.EXEC}, 32'h5555);

      // 4: redirect coincides with ack
      wait_req("t4");
      check("t4_addr", {16'd0, b1.IMEM_ADDR}, 32'h0041);
      b1.IMEM_ACK   = 1'b1;
      b1.IMEM_RDATA = 16'hABCD;
      b1.BR_TAKEN   = 1'b1;
      b1.BR_TARGET  = 16'h0100;
      b1.EXEC_READY = 1'b0;
      @(negedge clk);
      b1.IMEM_ACK   = 1'b0;
      b1.IMEM_RDATA = 16'h0000;
      b1.BR_TAKEN   = 1'b0;
      check("t4_valid", {31'd0, b1.EXEC_VALID}, 32'd0);
      check("t4_req",   {31'd0, b1.IMEM_REQ},   32'd0);
      serve("t4n", 16'h0100, 16'h0777, 1);
      check("t4n_exec", {16'd0, b1.EXEC}, 32'h0777);

      // redirect from HOLD, then predecode check at PC 0x10
      b1.BR_TAKEN  = 1'b1;
      b1.BR_TARGET = 16'h0010;
      @(negedge clk);
      b1.BR_TAKEN = 1'b0;
      check("t6_hold_redirect_valid", {31'd0, b1.EXEC_VALID}, 32'd0);
      serve("t6", 16'h0010, 16'hA0FE, 1);
      check("t6_exec", {16'd0, b1.EXEC}, 32'hA0FE);
      b1.EXEC_READY = 1'b1;
      wait_req("t6n");
`ifdef FETCH_PREDECODE_EN
      check("t6_next_addr", {16'd0, b1.IMEM_ADDR}, 32'h000F);
`else
      check("t6_next_addr", {16'd0, b1.IMEM_ADDR}, 32'h0011);
`endif

      // 5: PC wrap on the RESET_PC=FFFF instance
      do_reset();
      n = 0;
      while (b2.IMEM_REQ !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_req0",  {31'd0, b2.IMEM_REQ},  32'd1);
      check("t5_addr0", {16'd0, b2.IMEM_ADDR}, 32'hFFFF);
      b2.IMEM_ACK   = 1'b1;
      b2.IMEM_RDATA = 16'h0000;
      @(negedge clk);
      b2.IMEM_ACK = 1'b0;
      n = 0;
      while (b2.IMEM_REQ !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t5_req1",  {31'd0, b2.IMEM_REQ},  32'd1);
      check("t5_addr1", {16'd0, b2.IMEM_ADDR}, 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
